// File: rtl/vga_pkg.sv
// Shared constants and types for the VGA sprite engine: default 640x480@60
// timing, direction button bit positions, colour width and motion modes.
package vga_pkg;

  localparam int VGA_H_DISPLAY = 640;
  localparam int VGA_H_FRONT   = 16;
  localparam int VGA_H_SYNC    = 96;
  localparam int VGA_H_BACK    = 48;
  localparam int VGA_V_DISPLAY = 480;
  localparam int VGA_V_FRONT   = 10;
  localparam int VGA_V_SYNC    = 2;
  localparam int VGA_V_BACK    = 33;

  localparam int DIR_UP    = 3;
  localparam int DIR_DOWN  = 2;
  localparam int DIR_LEFT  = 1;
  localparam int DIR_RIGHT = 0;

  localparam int RGB_W = 6;

  typedef enum logic {
    MODE_WRAP   = 1'b0,
    MODE_BOUNCE = 1'b1
  } mode_e;

endpackage

// File: rtl/vga_timing.sv
// Raster counters with combinational sync/display decode and the once-per-frame
// update strobe at the start of the first vertical blanking line.
module vga_timing
  import vga_pkg::*;
#(
  parameter int H_DISPLAY = VGA_H_DISPLAY,
  parameter int H_FRONT   = VGA_H_FRONT,
  parameter int H_SYNC    = VGA_H_SYNC,
  parameter int H_BACK    = VGA_H_BACK,
  parameter int V_DISPLAY = VGA_V_DISPLAY,
  parameter int V_FRONT   = VGA_V_FRONT,
  parameter int V_SYNC    = VGA_V_SYNC,
  parameter int V_BACK    = VGA_V_BACK,
  parameter int SYNC_POL  = 0,
  parameter int HW        = $clog2(H_DISPLAY + H_FRONT + H_SYNC + H_BACK),
  parameter int VW        = $clog2(V_DISPLAY + V_FRONT + V_SYNC + V_BACK)
) (
  input  logic          clk,
  input  logic          rst_n,
  output logic [HW-1:0] o_h,
  output logic [VW-1:0] o_v,
  output logic          o_hsync,
  output logic          o_vsync,
  output logic          o_display_on,
  output logic          o_update
);

  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

  localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);
  localparam logic [HW-1:0] H_VIS      = HW'(H_DISPLAY);
  localparam logic [VW-1:0] V_VIS      = VW'(V_DISPLAY);
  localparam logic [HW-1:0] H_SYNC_ON  = HW'(H_DISPLAY + H_FRONT);
  localparam logic [HW-1:0] H_SYNC_OFF = HW'(H_DISPLAY + H_FRONT + H_SYNC - 1);
  localparam logic [VW-1:0] V_SYNC_ON  = VW'(V_DISPLAY + V_FRONT);
  localparam logic [VW-1:0] V_SYNC_OFF = VW'(V_DISPLAY + V_FRONT + V_SYNC - 1);
  localparam logic          SYNC_ACT   = (SYNC_POL != 0);

  logic [HW-1:0] r_h;
  logic [VW-1:0] r_v;
  logic          w_hs_act;
  logic          w_vs_act;

  // Horizontal counter wraps every line; vertical advances on the line wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_h <= '0;
      r_v <= '0;
    end else if (r_h == H_LAST) begin
      r_h <= '0;
      if (r_v == V_LAST) begin
        r_v <= '0;
      end else begin
        r_v <= r_v + 1'b1;
      end
    end else begin
      r_h <= r_h + 1'b1;
    end
  end

  // Decode sync pulses, active area and the movement strobe from the counters.
  always_comb begin
    w_hs_act     = (r_h >= H_SYNC_ON) && (r_h <= H_SYNC_OFF);
    w_vs_act     = (r_v >= V_SYNC_ON) && (r_v <= V_SYNC_OFF);
    o_hsync      = w_hs_act ? SYNC_ACT : ~SYNC_ACT;
    o_vsync      = w_vs_act ? SYNC_ACT : ~SYNC_ACT;
    o_display_on = (r_h < H_VIS) && (r_v < V_VIS);
    o_update     = (r_h == '0) && (r_v == V_VIS);
  end

  assign o_h = r_h;
  assign o_v = r_v;

endmodule

// File: rtl/vga_sprite_engine.sv
// Parametrised VGA timing plus a square sprite that wraps or bounces under
// button control; all outputs leave through one aligned register stage.
module vga_sprite_engine
  import vga_pkg::*;
#(
  parameter int H_DISPLAY = VGA_H_DISPLAY,
  parameter int H_FRONT   = VGA_H_FRONT,
  parameter int H_SYNC    = VGA_H_SYNC,
  parameter int H_BACK    = VGA_H_BACK,
  parameter int V_DISPLAY = VGA_V_DISPLAY,
  parameter int V_FRONT   = VGA_V_FRONT,
  parameter int V_SYNC    = VGA_V_SYNC,
  parameter int V_BACK    = VGA_V_BACK,
  parameter int SYNC_POL  = 0,
  parameter int SPRITE_SIZE = 16,
  parameter int SPEED_W   = 3,
  parameter logic [RGB_W-1:0] SPRITE_RGB = 6'b110000,
  parameter logic [RGB_W-1:0] BG_RGB     = 6'b000001,
  localparam int HW = $clog2(H_DISPLAY + H_FRONT + H_SYNC + H_BACK),
  localparam int VW = $clog2(V_DISPLAY + V_FRONT + V_SYNC + V_BACK)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [3:0]         dir_i,
  input  logic [SPEED_W-1:0] speed_i,
  input  logic               mode_i,
  output logic               hsync_o,
  output logic               vsync_o,
  output logic               display_on_o,
  output logic [RGB_W-1:0]   rgb_o,
  output logic [HW-1:0]      hpos_o,
  output logic [VW-1:0]      vpos_o,
  output logic               frame_tick_o
);

  // One spare bit above the wider axis so step arithmetic cannot overflow.
  localparam int CW = ((HW > VW) ? HW : VW) + 1;

  localparam logic [CW-1:0] X_MAXC  = CW'(H_DISPLAY - SPRITE_SIZE);
  localparam logic [CW-1:0] Y_MAXC  = CW'(V_DISPLAY - SPRITE_SIZE);
  localparam logic [CW-1:0] X_START = CW'((H_DISPLAY - SPRITE_SIZE) / 2);
  localparam logic [CW-1:0] Y_START = CW'((V_DISPLAY - SPRITE_SIZE) / 2);
  localparam logic [CW-1:0] SIZE_C  = CW'(SPRITE_SIZE);
  localparam logic          SYNC_ACT = (SYNC_POL != 0);

  function automatic logic [CW-1:0] wrap_move(
    input logic [CW-1:0] p,
    input logic [CW-1:0] step,
    input logic [CW-1:0] maxv,
    input logic          plus,
    input logic          minus
  );
    logic [CW-1:0] n;
    n = p;
    if (plus && !minus) begin
      n = p + step;
      if (n > maxv) begin
        n = n - (maxv + 1'b1);
      end else begin
        n = p + step;
      end
    end else if (minus && !plus) begin
      if (p < step) begin
        n = p + maxv + 1'b1 - step;
      end else begin
        n = p - step;
      end
    end else begin
      n = p;
    end
    return n;
  endfunction

  // Returns {sign, position}; sign 1 means moving towards larger coordinates.
  function automatic logic [CW:0] bounce_move(
    input logic [CW-1:0] p,
    input logic [CW-1:0] step,
    input logic [CW-1:0] maxv,
    input logic          sign,
    input logic          plus,
    input logic          minus
  );
    logic          s;
    logic [CW-1:0] n;
    n = p;
    if (plus && !minus) begin
      s = 1'b1;
    end else if (minus && !plus) begin
      s = 1'b0;
    end else begin
      s = sign;
    end
    if (step == '0) begin
      s = sign;
      n = p;
    end else if (s) begin
      if (p + step >= maxv) begin
        n = maxv;
        s = 1'b0;
      end else begin
        n = p + step;
      end
    end else begin
      if (p <= step) begin
        n = '0;
        s = 1'b1;
      end else begin
        n = p - step;
      end
    end
    return {s, n};
  endfunction

  logic [HW-1:0]    w_h;
  logic [VW-1:0]    w_v;
  logic             w_hsync;
  logic             w_vsync;
  logic             w_display_on;
  logic             w_update;

  logic [CW-1:0]    r_sx;
  logic [CW-1:0]    r_sy;
  logic             r_sign_x;
  logic             r_sign_y;

  logic [CW-1:0]    w_step;
  logic [CW:0]      w_bx;
  logic [CW:0]      w_by;
  logic [CW-1:0]    w_sx_nxt;
  logic [CW-1:0]    w_sy_nxt;
  logic             w_sign_x_nxt;
  logic             w_sign_y_nxt;
  logic [CW-1:0]    w_h_ext;
  logic [CW-1:0]    w_v_ext;
  logic             w_hit;
  logic [RGB_W-1:0] w_rgb;

  logic             r_hsync;
  logic             r_vsync;
  logic             r_display_on;
  logic [RGB_W-1:0] r_rgb;
  logic [HW-1:0]    r_hpos;
  logic [VW-1:0]    r_vpos;
  logic             r_frame_tick;

  vga_timing #(
    .H_DISPLAY (H_DISPLAY),
    .H_FRONT   (H_FRONT),
    .H_SYNC    (H_SYNC),
    .H_BACK    (H_BACK),
    .V_DISPLAY (V_DISPLAY),
    .V_FRONT   (V_FRONT),
    .V_SYNC    (V_SYNC),
    .V_BACK    (V_BACK),
    .SYNC_POL  (SYNC_POL),
    .HW        (HW),
    .VW        (VW)
  ) u_timing (
    .clk          (clk),
    .rst_n        (rst_n),
    .o_h          (w_h),
    .o_v          (w_v),
    .o_hsync      (w_hsync),
    .o_vsync      (w_vsync),
    .o_display_on (w_display_on),
    .o_update     (w_update)
  );

  // Next sprite position and bounce signs for the coming update point.
  always_comb begin
    w_step = CW'(speed_i);
    w_bx   = bounce_move(r_sx, w_step, X_MAXC, r_sign_x,
                         dir_i[DIR_RIGHT], dir_i[DIR_LEFT]);
    w_by   = bounce_move(r_sy, w_step, Y_MAXC, r_sign_y,
                         dir_i[DIR_DOWN], dir_i[DIR_UP]);
    if (mode_i == MODE_BOUNCE) begin
      w_sx_nxt     = w_bx[CW-1:0];
      w_sy_nxt     = w_by[CW-1:0];
      w_sign_x_nxt = w_bx[CW];
      w_sign_y_nxt = w_by[CW];
    end else begin
      w_sx_nxt     = wrap_move(r_sx, w_step, X_MAXC,
                               dir_i[DIR_RIGHT], dir_i[DIR_LEFT]);
      w_sy_nxt     = wrap_move(r_sy, w_step, Y_MAXC,
                               dir_i[DIR_DOWN], dir_i[DIR_UP]);
      w_sign_x_nxt = r_sign_x;
      w_sign_y_nxt = r_sign_y;
    end
  end

  // Sprite state changes only on the first blank line, so no frame tears.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sx     <= X_START;
      r_sy     <= Y_START;
      r_sign_x <= 1'b1;
      r_sign_y <= 1'b1;
    end else if (w_update) begin
      r_sx     <= w_sx_nxt;
      r_sy     <= w_sy_nxt;
      r_sign_x <= w_sign_x_nxt;
      r_sign_y <= w_sign_y_nxt;
    end else begin
      r_sx     <= r_sx;
      r_sy     <= r_sy;
      r_sign_x <= r_sign_x;
      r_sign_y <= r_sign_y;
    end
  end

  // Colour mux: blanking is forced black regardless of sprite overlap.
  always_comb begin
    w_h_ext = CW'(w_h);
    w_v_ext = CW'(w_v);
    w_hit   = (w_h_ext >= r_sx) && (w_h_ext < r_sx + SIZE_C) &&
              (w_v_ext >= r_sy) && (w_v_ext < r_sy + SIZE_C);
    w_rgb   = '0;
    if (w_display_on) begin
      w_rgb = w_hit ? SPRITE_RGB : BG_RGB;
    end else begin
      w_rgb = '0;
    end
  end

  // Single output stage keeps position, syncs and colour mutually aligned.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hsync      <= ~SYNC_ACT;
      r_vsync      <= ~SYNC_ACT;
      r_display_on <= 1'b0;
      r_rgb        <= '0;
      r_hpos       <= '0;
      r_vpos       <= '0;
      r_frame_tick <= 1'b0;
    end else begin
      r_hsync      <= w_hsync;
      r_vsync      <= w_vsync;
      r_display_on <= w_display_on;
      r_rgb        <= w_rgb;
      r_hpos       <= w_h;
      r_vpos       <= w_v;
      r_frame_tick <= w_update;
    end
  end

  assign hsync_o      = r_hsync;
  assign vsync_o      = r_vsync;
  assign display_on_o = r_display_on;
  assign rgb_o        = r_rgb;
  assign hpos_o       = r_hpos;
  assign vpos_o       = r_vpos;
  assign frame_tick_o = r_frame_tick;

endmodule

// File: tb/tb_vga_sprite_engine.sv
// Directed bench for vga_sprite_engine on a reduced 48x30 raster (32x24 visible,
// 4-pixel sprite) so many frames fit in a short run.
module tb_vga_sprite_engine;

  localparam int HD = 32, HF = 4, HS = 8, HB = 4;
  localparam int VD = 24, VF = 2, VS = 2, VB = 2;
  localparam int HT = HD + HF + HS + HB;   // 48
  localparam int VT = VD + VF + VS + VB;   // 30
  localparam int SZ = 4;
  localparam int FRAME = HT * VT;          // 1440

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [3:0] dir_i = 4'b0000;
  logic [2:0] speed_i = 3'd0;
  logic       mode_i = 1'b0;
  logic       hsync_o, vsync_o, display_on_o, frame_tick_o;
  logic [5:0] rgb_o;
  logic [5:0] hpos_o;
  logic [4:0] vpos_o;

  int n_tests = 0;
  int n_fail  = 0;

  vga_sprite_engine #(
    .H_DISPLAY(HD), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_DISPLAY(VD), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .SYNC_POL(0), .SPRITE_SIZE(SZ), .SPEED_W(3),
    .SPRITE_RGB(6'b110000), .BG_RGB(6'b000001)
  ) dut (
    .clk(clk), .rst_n(rst_n), .dir_i(dir_i), .speed_i(speed_i), .mode_i(mode_i),
    .hsync_o(hsync_o), .vsync_o(vsync_o), .display_on_o(display_on_o),
    .rgb_o(rgb_o), .hpos_o(hpos_o), .vpos_o(vpos_o), .frame_tick_o(frame_tick_o)
  );

  always #5 clk = ~clk;

  // Advance to the negedge just after the next frame tick.
  task automatic next_frame();
    bit seen = 1'b0;
    for (int i = 0; i < FRAME + 100; i++) begin
      @(negedge clk);
      if (frame_tick_o === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    n_tests++;
    if (!seen) begin
      n_fail++;
      $display("FAIL frame_tick_wait: got no tick, required one within %0d cycles", FRAME + 100);
    end
  endtask

  task automatic wait_pos(input int x, input int y, output bit found);
    found = 1'b0;
    for (int i = 0; i < FRAME + 100; i++) begin
      @(negedge clk);
      if (int'(hpos_o) == x && int'(vpos_o) == y) begin
        found = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    n_tests += 9;
    if (hsync_o !== 1'b1) begin n_fail++; $display("FAIL reset_hsync: got %b want 1", hsync_o); end
    if (vsync_o !== 1'b1) begin n_fail++; $display("FAIL reset_vsync: got %b want 1", vsync_o); end
    if (display_on_o !== 1'b0) begin n_fail++; $display("FAIL reset_de: got %b want 0", display_on_o); end
    if (rgb_o !== 6'd0) begin n_fail++; $display("FAIL reset_rgb: got %b want 0", rgb_o); end
    if (hpos_o !== 6'd0) begin n_fail++; $display("FAIL reset_hpos: got %0d want 0", hpos_o); end
    if (vpos_o !== 5'd0) begin n_fail++; $display("FAIL reset_vpos: got %0d want 0", vpos_o); end
    if (frame_tick_o !== 1'b0) begin n_fail++; $display("FAIL reset_tick: got %b want 0", frame_tick_o); end
    if (int'(dut.r_sx) != 14) begin n_fail++; $display("FAIL reset_sx: got %0d want 14", dut.r_sx); end
    if (int'(dut.r_sy) != 10) begin n_fail++; $display("FAIL reset_sy: got %0d want 10", dut.r_sy); end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Two full frames from reset release, each output checked against a raster model.
  task automatic test_timing();
    int eh = 0, ev = 0;
    int e_pos = 0, e_hs = 0, e_vs = 0, e_de = 0, e_rgb = 0, e_tick = 0;
    int ticks = 0, t1 = -1, t2 = -1;
    logic xhs, xvs, xde, xtick;
    logic [5:0] xrgb;
    for (int cyc = 0; cyc < 2 * FRAME; cyc++) begin
      @(negedge clk);
      xhs   = !(eh >= 36 && eh <= 43);
      xvs   = !(ev >= 26 && ev <= 27);
      xde   = (eh < HD) && (ev < VD);
      xtick = (eh == 0) && (ev == VD);
      xrgb  = !xde ? 6'b000000 :
              ((eh >= 14 && eh < 18 && ev >= 10 && ev < 14) ? 6'b110000 : 6'b000001);
      if (int'(hpos_o) != eh || int'(vpos_o) != ev) e_pos++;
      if (hsync_o !== xhs) e_hs++;
      if (vsync_o !== xvs) e_vs++;
      if (display_on_o !== xde) e_de++;
      if (rgb_o !== xrgb) e_rgb++;
      if (frame_tick_o !== xtick) e_tick++;
      if (frame_tick_o === 1'b1) begin
        ticks++;
        if (t1 < 0) t1 = cyc; else if (t2 < 0) t2 = cyc;
      end
      eh++;
      if (eh == HT) begin eh = 0; ev = (ev == VT - 1) ? 0 : ev + 1; end
    end
    n_tests += 8;
    if (e_pos != 0)  begin n_fail++; $display("FAIL timing_pos: %0d bad cycles, want 0", e_pos); end
    if (e_hs != 0)   begin n_fail++; $display("FAIL timing_hsync: %0d bad cycles, want 0", e_hs); end
    if (e_vs != 0)   begin n_fail++; $display("FAIL timing_vsync: %0d bad cycles, want 0", e_vs); end
    if (e_de != 0)   begin n_fail++; $display("FAIL timing_de: %0d bad cycles, want 0", e_de); end
    if (e_rgb != 0)  begin n_fail++; $display("FAIL timing_rgb: %0d bad cycles, want 0", e_rgb); end
    if (e_tick != 0) begin n_fail++; $display("FAIL timing_tick: %0d bad cycles, want 0", e_tick); end
    if (ticks != 2)  begin n_fail++; $display("FAIL tick_count: got %0d want 2", ticks); end
    if (t2 - t1 != FRAME) begin n_fail++; $display("FAIL tick_period: got %0d want %0d", t2 - t1, FRAME); end
  endtask

  task automatic test_pixels();
    int px [4];
    int py [4];
    logic [5:0] pe [4];
    bit found;
    px = '{14, 18, 17, 40};
    py = '{10, 10, 13, 13};
    pe = '{6'b110000, 6'b000001, 6'b110000, 6'b000000};
    for (int i = 0; i < 4; i++) begin
      wait_pos(px[i], py[i], found);
      n_tests++;
      if (!found) begin
        n_fail++;
        $display("FAIL pixel_%0d_%0d: position never reached, want rgb %b", px[i], py[i], pe[i]);
      end else if (rgb_o !== pe[i]) begin
        n_fail++;
        $display("FAIL pixel_%0d_%0d: got rgb %b want %b", px[i], py[i], rgb_o, pe[i]);
      end
    end
  endtask

  task automatic test_wrap();
    logic [3:0] d [8];
    int sp [8];
    int ex [8];
    int ey [8];
    d  = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0010, 4'b0100, 4'b0100, 4'b1000};
    sp = '{3, 5, 5, 3, 3, 7, 7, 7};
    ex = '{17, 22, 27, 1, 27, 27, 27, 27};
    ey = '{10, 10, 10, 10, 10, 17, 3, 17};
    mode_i = 1'b0;
    for (int i = 0; i < 8; i++) begin
      dir_i = d[i];
      speed_i = 3'(sp[i]);
      next_frame();
      n_tests += 2;
      if (int'(dut.r_sx) != ex[i]) begin n_fail++; $display("FAIL wrap_x_%0d: got %0d want %0d", i, dut.r_sx, ex[i]); end
      if (int'(dut.r_sy) != ey[i]) begin n_fail++; $display("FAIL wrap_y_%0d: got %0d want %0d", i, dut.r_sy, ey[i]); end
    end
  endtask

  task automatic test_bounce();
    logic [3:0] d [9];
    int sp [9];
    int ex [9];
    int ey [9];
    d  = '{4'b0000, 4'b0000, 4'b0001, 4'b0000, 4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0000};
    sp = '{3, 3, 1, 1, 7, 7, 7, 7, 7};
    ex = '{28, 25, 26, 27, 20, 13, 6, 0, 7};
    ey = '{20, 17, 16, 15, 8, 1, 0, 7, 14};
    mode_i = 1'b1;
    for (int i = 0; i < 9; i++) begin
      dir_i = d[i];
      speed_i = 3'(sp[i]);
      next_frame();
      n_tests += 2;
      if (int'(dut.r_sx) != ex[i]) begin n_fail++; $display("FAIL bounce_x_%0d: got %0d want %0d", i, dut.r_sx, ex[i]); end
      if (int'(dut.r_sy) != ey[i]) begin n_fail++; $display("FAIL bounce_y_%0d: got %0d want %0d", i, dut.r_sy, ey[i]); end
    end
  endtask

  // Opposing buttons and zero speed must freeze the sprite and its signs.
  task automatic test_hold();
    logic [3:0] d [11];
    int sp [11];
    logic md [11];
    int ex [11];
    int ey [11];
    d  = '{4'b1111, 4'b1111, 4'b1111, 4'b0001, 4'b0001, 4'b0001,
           4'b0010, 4'b0010, 4'b0010, 4'b0000, 4'b1100};
    sp = '{5, 5, 5, 0, 0, 0, 0, 0, 0, 1, 1};
    md = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    ex = '{7, 7, 7, 7, 7, 7, 7, 7, 7, 8, 9};
    ey = '{14, 14, 14, 14, 14, 14, 14, 14, 14, 15, 16};
    for (int i = 0; i < 11; i++) begin
      dir_i = d[i];
      speed_i = 3'(sp[i]);
      mode_i = md[i];
      next_frame();
      n_tests += 2;
      if (int'(dut.r_sx) != ex[i]) begin n_fail++; $display("FAIL hold_x_%0d: got %0d want %0d", i, dut.r_sx, ex[i]); end
      if (int'(dut.r_sy) != ey[i]) begin n_fail++; $display("FAIL hold_y_%0d: got %0d want %0d", i, dut.r_sy, ey[i]); end
    end
  endtask

  task automatic test_reset_mid();
    bit found;
    int cnt = 0;
    bit seen = 1'b0;
    dir_i = 4'b0000;
    speed_i = 3'd0;
    mode_i = 1'b0;
    wait_pos(10, 5, found);
    n_tests++;
    if (!found) begin n_fail++; $display("FAIL midreset_pos: position (10,5) never reached, want reached"); end
    #2 rst_n = 1'b0;
    #1;
    n_tests += 6;
    if (hsync_o !== 1'b1) begin n_fail++; $display("FAIL midreset_hsync: got %b want 1", hsync_o); end
    if (vsync_o !== 1'b1) begin n_fail++; $display("FAIL midreset_vsync: got %b want 1", vsync_o); end
    if (rgb_o !== 6'd0) begin n_fail++; $display("FAIL midreset_rgb: got %b want 0", rgb_o); end
    if (display_on_o !== 1'b0) begin n_fail++; $display("FAIL midreset_de: got %b want 0", display_on_o); end
    if (int'(dut.r_sx) != 14) begin n_fail++; $display("FAIL midreset_sx: got %0d want 14", dut.r_sx); end
    if (int'(dut.r_sy) != 10) begin n_fail++; $display("FAIL midreset_sy: got %0d want 10", dut.r_sy); end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < FRAME + 100; i++) begin
      @(negedge clk);
      cnt++;
      if (frame_tick_o === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    n_tests++;
    if (!seen || cnt != VD * HT + 1) begin
      n_fail++;
      $display("FAIL midreset_first_tick: got tick after %0d cycles (seen=%0d) want %0d", cnt, seen, VD * HT + 1);
    end
  endtask

  initial begin
    test_reset();
    test_timing();
    test_pixels();
    test_wrap();
    test_bounce();
    test_hold();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_sprite_engine.md
Name: vga_sprite_engine

Overview:
Parametrised successor to the fixed-resolution VGA direction demo. It generates VGA timing for any mode given as parameters, and moves a square sprite under direction-button control. The sprite either wraps at the screen edges or bounces off them autonomously. It sits below the tt_um top wrapper, which maps ui_in to buttons and uo_out to the 2-bit-per-channel VGA PMOD.

Parameters:
H_DISPLAY, 640, visible pixels per line
H_FRONT, 16, horizontal front porch
H_SYNC, 96, hsync width
H_BACK, 48, horizontal back porch
V_DISPLAY, 480, visible lines
V_FRONT, 10, vertical front porch
V_SYNC, 2, vsync width
V_BACK, 33, vertical back porch
SYNC_POL, 0, sync active level (0 = active low)
SPRITE_SIZE, 16, sprite edge length in pixels
SPEED_W, 3, width of speed input
SPRITE_RGB, 6'b110000, sprite colour {R1R0,G1G0,B1B0}
BG_RGB, 6'b000001, background colour in the active area
Derived: H_TOTAL=sum of H_*; V_TOTAL=sum of V_*; X_MAX=H_DISPLAY-SPRITE_SIZE; Y_MAX=V_DISPLAY-SPRITE_SIZE; HW=$clog2(H_TOTAL); VW=$clog2(V_TOTAL).

Ports:
clk  in  1  pixel clock
rst_n  in  1  asynchronous active-low reset
dir_i  in  4  buttons {up,down,left,right}, active high
speed_i  in  SPEED_W  pixels moved per frame; 0 = stationary
mode_i  in  1  0 = wrap, 1 = bounce
hsync_o  out  1  horizontal sync
vsync_o  out  1  vertical sync
display_on_o  out  1  pixel is in the active area
rgb_o  out  6  pixel colour
hpos_o  out  HW  x coordinate of the pixel currently on rgb_o
vpos_o  out  VW  y coordinate of the pixel currently on rgb_o
frame_tick_o  out  1  one-cycle pulse per frame at the movement update

Behaviour:
- Reset (async assert, sync release):
  - counters = 0.
  - sx = X_MAX/2, sy = Y_MAX/2 (312/232 at defaults).
  - Bounce signs = +x, +y.
  - hsync_o/vsync_o = ~SYNC_POL.
  - display_on_o, rgb_o, hpos_o, vpos_o, frame_tick_o = 0.
- Counters:
  - h counts 0..H_TOTAL-1 and wraps to 0.
  - v increments on the h wrap, counts 0..V_TOTAL-1, and wraps.
- Decode:
  - hsync is active for h in [H_DISPLAY+H_FRONT, H_DISPLAY+H_FRONT+H_SYNC-1]. vsync is decoded the same way from v.
  - display_on = h<H_DISPLAY && v<V_DISPLAY.
- Output stage: every output is registered one stage after the counters (latency 1). hpos_o and vpos_o are the delayed counter values, so all outputs are mutually aligned.
- Pixel colour:
  - SPRITE_RGB when display_on && sx<=h<sx+SPRITE_SIZE && sy<=v<sy+SPRITE_SIZE.
  - BG_RGB when display_on otherwise.
  - 0 outside the active area (blanking must be black).
- Update point:
  - Movement happens on the cycle where counter h==0 and v==V_DISPLAY, i.e. the first blank line, so there is no tearing.
  - frame_tick_o is registered off that cycle.
  - dir_i, speed_i and mode_i are sampled only at the update point.
- Wrap mode, per axis:
  - Both opposing buttons pressed, or neither: no motion on that axis.
  - +step: n = p+step. If n > MAX, then n = n-(MAX+1).
  - -step: if p < step, then n = p+(MAX+1)-step; else n = p-step.
  - Compute in width max(HW,VW)+1 so nothing overflows.
- Bounce mode, per axis:
  - The sprite moves every frame by step in its sign direction.
  - A single pressed button on an axis forces that axis sign before the move. Opposing buttons pressed together leave the sign unchanged.
  - A move that would go past 0 or past MAX clamps to the edge and inverts the sign. Landing exactly on the edge also inverts the sign.
- Mode switch: takes effect at the next update point. Bounce signs persist across mode switches.
- speed_i = 0: no position or sign change in either mode. frame_tick_o still pulses.
- Reset mid-frame: everything returns to reset values immediately. The first frame_tick_o after release comes at the cycle after counter reaches (0, V_DISPLAY).

Decomposition:
- Package vga_pkg holds:
  - 640x480@60 timing constants.
  - Direction bit indices DIR_UP=3, DIR_DOWN=2, DIR_LEFT=1, DIR_RIGHT=0.
  - RGB_W=6.
  - Mode enum MODE_WRAP/MODE_BOUNCE.
- Sub-module vga_timing contains the counters, sync/display decode and the update-point strobe, parametrised by the H_*/V_*/SYNC_POL parameters. Sprite position, update logic and colour mux stay in the parent.

Test Plan:
- Defaults, reset released, no buttons:
  - hsync_o is low for output cycles with hpos_o 656..751 and high elsewhere.
  - vsync_o is low for vpos_o 490..491.
  - frame_tick_o period = 420000 clocks.
- Pixel colour at reset position:
  - rgb_o = 6'b110000 at (312,232) and at (327,247).
  - rgb_o = 6'b000001 at (328,232).
  - rgb_o = 0 at hpos_o 700.
- Wrap move: dir_i=0001, speed_i=3, mode 0.
  - After one frame_tick_o, sx = 315.
  - Preload to sx = 623; after one frame, sx = 1.
  - dir_i=0010, speed 3 from sx = 1 gives sx = 623.
- Bounce: mode 1, sx = 623 with +x sign, speed 3.
  - Next frame sx = 624 with sign flipped; following frame sx = 621.
  - dir_i=0001 held then forces +x again.
- Opposing buttons and speed 0: dir_i=1111 in wrap mode, and separately speed_i=0, leave (sx,sy) unchanged across 3 frames.
- Async reset asserted mid-line:
  - Outputs go to reset values without a clock edge: hsync_o = vsync_o = 1, rgb_o = 0.
  - Sprite returns to (312,232).
